// File: rtl/frame_loader_pkg.sv
// Shared types for the framed operand loader.
//   state_t : loader FSM states
//   err_t   : values reported on err_code
//   SYNC_BYTE_DEFAULT : default frame start marker
package frame_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ARM,
    ST_FIRE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_loader_timeout.sv
// Inter-byte idle counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return the count to zero
//   count_en   : one more idle cycle has elapsed
//   expired    : this idle cycle is the TIMEOUT_CYC-th in a row
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flagged combinationally so the loader reacts on the very edge that
  // completes the idle run.
  assign expired = count_en && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/frame_loader.sv
// Framed operand loader: sync byte, NUM_WORDS*WORD_W/8 payload bytes
// (word 0 first, MSB byte first), XOR checksum byte. Verified operands are
// held on words_out and a one-cycle start is issued once the core is idle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : global enable, low freezes everything
//   byte_in     : stream byte, qualified by byte_valid
//   core_busy   : core cannot accept a start
//   words_out   : verified operands, word k at [k*WORD_W +: WORD_W]
//   start_calc  : one-cycle start pulse
//   loader_busy : high outside IDLE
//   err_valid   : one-cycle error pulse
//   err_code    : last error (1 checksum, 2 timeout, 3 overrun)
//   err_cnt     : saturating error count
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned NUM_WORDS   = 2,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  input  logic                          core_busy,
  output logic [NUM_WORDS*WORD_W-1:0]   words_out,
  output logic                          start_calc,
  output logic                          loader_busy,
  output logic                          err_valid,
  output logic [1:0]                    err_code,
  output logic [7:0]                    err_cnt
);

  localparam int unsigned TOTAL_W = NUM_WORDS * WORD_W;
  localparam int unsigned NBYTES  = TOTAL_W / 8;
  localparam int unsigned IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         csum;
  logic [TOTAL_W-1:0] shadow;

  logic accepted;
  logic in_frame;
  logic tmo_expired;
  logic err_hit;
  err_t err_kind;

  assign accepted = ena && byte_valid;
  assign in_frame = (state == ST_LOAD) || (state == ST_CHECK);

  byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ena && (accepted || !in_frame)),
    .count_en (ena && in_frame && !accepted),
    .expired  (tmo_expired)
  );

  // The shadow is a plain shift register, so word 0 ends up in the top
  // slot; flip word order when publishing to words_out.
  function automatic logic [TOTAL_W-1:0] reorder(input logic [TOTAL_W-1:0] s);
    logic [TOTAL_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      r[k*WORD_W +: WORD_W] = s[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
    end
    return r;
  endfunction

  always_comb begin
    err_hit  = 1'b0;
    err_kind = ERR_NONE;
    if (ena) begin
      case (state)
        ST_LOAD, ST_CHECK: begin
          if (tmo_expired) begin
            err_hit  = 1'b1;
            err_kind = ERR_TIMEOUT;
          end else if (state == ST_CHECK && accepted && byte_in != csum) begin
            err_hit  = 1'b1;
            err_kind = ERR_CHECKSUM;
          end
        end
        ST_ARM, ST_FIRE: begin
          if (accepted) begin
            err_hit  = 1'b1;
            err_kind = ERR_OVERRUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      csum        <= '0;
      shadow      <= '0;
      words_out   <= '0;
      start_calc  <= 1'b0;
      loader_busy <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_cnt     <= '0;
    end else if (!ena) begin
      start_calc <= 1'b0;
      err_valid  <= 1'b0;
    end else begin
      start_calc <= 1'b0;
      err_valid  <= err_hit;
      if (err_hit) begin
        err_code <= err_kind;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (accepted && byte_in == SYNC_BYTE) begin
            state       <= ST_LOAD;
            idx         <= '0;
            csum        <= '0;
            loader_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (tmo_expired) begin
            state       <= ST_IDLE;
            loader_busy <= 1'b0;
          end else if (accepted) begin
            shadow <= (shadow << 8) | TOTAL_W'(byte_in);
            csum   <= csum ^ byte_in;
            idx    <= idx + IDX_W'(1);
            if (idx == IDX_W'(NBYTES - 1)) begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (tmo_expired) begin
            state       <= ST_IDLE;
            loader_busy <= 1'b0;
          end else if (accepted) begin
            if (byte_in == csum) begin
              words_out <= reorder(shadow);
              state     <= ST_ARM;
            end else begin
              state       <= ST_IDLE;
              loader_busy <= 1'b0;
            end
          end
        end
        ST_ARM: begin
          if (!core_busy) begin
            state      <= ST_FIRE;
            start_calc <= 1'b1;
          end
        end
        ST_FIRE: begin
          // A pulse suppressed by ena going low is re-issued before leaving.
          if (start_calc) begin
            state       <= ST_IDLE;
            loader_busy <= 1'b0;
          end else begin
            start_calc <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          loader_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
